// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the issue-buffer entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU opcode layout is {funct7, 1'b0, funct3}
    localparam logic [10:0] ALU_ADD = 11'h000;
    localparam logic [10:0] ALU_SUB = 11'h200;
    localparam logic [10:0] ALU_SLL = 11'h001;
    localparam logic [10:0] ALU_SLT = 11'h002;
    localparam logic [10:0] ALU_XOR = 11'h004;
    localparam logic [10:0] ALU_SRL = 11'h005;
    localparam logic [10:0] ALU_SRA = 11'h205;
    localparam logic [10:0] ALU_OR  = 11'h006;
    localparam logic [10:0] ALU_AND = 11'h007;

    // Zero encodings are chosen so a reset entry yields all-zero outputs
    typedef enum logic [1:0] {SEL1_RS1 = 2'd0, SEL1_PC = 2'd1, SEL1_ZERO = 2'd2} sel1_t;
    typedef enum logic [1:0] {SEL2_RS2 = 2'd0, SEL2_IMM = 2'd1, SEL2_FOUR = 2'd2} sel2_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [10:0] alu_op;
        sel1_t       sel1;
        sel2_t       sel2;
        logic [4:0]  rd;
        logic        illegal;
    } issue_entry_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction for I/S/B/U/J formats, sign-extended from instr[31].
// Latency: combinational.
// Backpressure: none.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    // Pick the immediate format from the major opcode
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage: decodes RV32I, resolves ALU operands, forwards writeback, 2-entry skid buffer.
// Latency: instruction accepted at edge N is presented on the outputs after that edge.
// Backpressure: registered in_ready drops when the buffer will hold 2; flush empties it.
module alu_operand_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [10:0]     out_alu_op,
    output logic [XLEN-1:0] out_num1,
    output logic [XLEN-1:0] out_num2,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    issue_entry_t buf_q [2];
    issue_entry_t dec;
    issue_entry_t head;
    logic         head_q, tail_q;
    logic [1:0]   count_q, count_next;
    logic         in_ready_q;
    logic         push, pop;
    logic [1:0]   entry_vld;
    logic [31:0]  imm;

    // x0 never matches, so a zero destination cannot disturb operands
    function automatic logic fwd_match(input logic [4:0] idx);
        return FWD_EN && wb_en && (wb_rd != 5'd0) && (wb_rd == idx);
    endfunction

    imm_gen u_imm_gen (
        .instr (in_instr),
        .imm   (imm)
    );

    // Decode the incoming instruction into a buffer entry, with capture-time forwarding
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.rs1_idx = in_instr[19:15];
        dec.rs2_idx = in_instr[24:20];
        dec.rs1_val = fwd_match(in_instr[19:15]) ? wb_data : in_rs1_data;
        dec.rs2_val = fwd_match(in_instr[24:20]) ? wb_data : in_rs2_data;
        dec.imm     = imm;
        dec.alu_op  = ALU_ADD;
        dec.sel1    = SEL1_RS1;
        dec.sel2    = SEL2_IMM;
        dec.rd      = in_instr[11:7];
        case (in_instr[6:0])
            OPC_OP: begin
                dec.alu_op = {in_instr[31:25], 1'b0, in_instr[14:12]};
                dec.sel2   = SEL2_RS2;
            end
            OPC_OP_IMM: begin
                // Only SRAI carries a meaningful funct7 among the immediate ops
                dec.alu_op = {(in_instr[14:12] == 3'b101) ? in_instr[31:25] : 7'd0,
                              1'b0, in_instr[14:12]};
            end
            OPC_LOAD: ;
            OPC_STORE: dec.rd = 5'd0;
            OPC_BRANCH: begin
                dec.rd   = 5'd0;
                dec.sel2 = SEL2_RS2;
                case (in_instr[14:12])
                    3'b000, 3'b001: dec.alu_op = ALU_SUB;
                    3'b100, 3'b101: dec.alu_op = ALU_SLT;
                    default:        dec.alu_op = {8'd0, in_instr[14:12]};
                endcase
            end
            OPC_JAL: begin
                dec.sel1 = SEL1_PC;
                dec.sel2 = SEL2_FOUR;
            end
            OPC_JALR:  dec.sel2 = SEL2_FOUR;
            OPC_LUI:   dec.sel1 = SEL1_ZERO;
            OPC_AUIPC: dec.sel1 = SEL1_PC;
            default: begin
                dec.illegal = 1'b1;
                dec.alu_op  = '0;
                dec.sel1    = SEL1_ZERO;
                dec.rd      = 5'd0;
            end
        endcase
    end

    // Handshake bookkeeping and per-entry occupancy
    always_comb begin
        push         = in_valid & in_ready_q & ~flush;
        pop          = out_valid & out_ready;
        count_next   = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        entry_vld[0] = (count_q == 2'd2) || (count_q == 2'd1 && head_q == 1'b0);
        entry_vld[1] = (count_q == 2'd2) || (count_q == 2'd1 && head_q == 1'b1);
    end

    // Pointers, count and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            count_q    <= count_next;
            in_ready_q <= (count_next < 2'd2);
            if (flush) begin
                head_q <= 1'b0;
                tail_q <= 1'b0;
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;
            end
        end
    end

    // Entry storage: capture into the tail, otherwise let valid entries snoop writeback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push && tail_q == i[0]) begin
                    buf_q[i] <= dec;
                end else if (entry_vld[i]) begin
                    if (fwd_match(buf_q[i].rs1_idx)) buf_q[i].rs1_val <= wb_data;
                    if (fwd_match(buf_q[i].rs2_idx)) buf_q[i].rs2_val <= wb_data;
                end
            end
        end
    end

    // Output mux of the head entry with operand selection
    always_comb begin
        head         = buf_q[head_q];
        out_valid    = (count_q != 2'd0);
        in_ready     = in_ready_q;
        out_alu_op   = head.alu_op;
        out_rs2_data = head.rs2_val;
        out_rd       = head.rd;
        out_pc       = head.pc;
        out_illegal  = head.illegal;
        case (head.sel1)
            SEL1_PC:   out_num1 = head.pc;
            SEL1_ZERO: out_num1 = '0;
            default:   out_num1 = head.rs1_val;
        endcase
        case (head.sel2)
            SEL2_RS2:  out_num2 = head.rs2_val;
            SEL2_FOUR: out_num2 = 32'd4;
            default:   out_num2 = head.imm;
        endcase
        if (head.illegal) begin
            out_num1 = '0;
            out_num2 = '0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode, operands, skid buffer, forwarding, flush, reset.
// Latency: checks one cycle after acceptance.
// Backpressure: exercised via out_ready and registered in_ready.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_instr, in_rs1_data, in_rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [10:0] out_alu_op;
    logic [31:0] out_num1, out_num2, out_rs2_data, out_pc;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int errors = 0;
    int checks = 0;

    alu_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
        .out_num1(out_num1), .out_num2(out_num2), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_pc = 0; in_instr = 0; in_rs1_data = 0; in_rs2_data = 0;
        wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if ({out_alu_op, out_num1, out_num2, out_rd, out_pc, out_rs2_data, out_illegal} !== '0)
            begin errors++; $display("FAIL reset_data: outputs not all zero (num1=%h num2=%h)", out_num1, out_num2); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_add();
        out_ready = 1; in_valid = 1; in_instr = 32'h003100B3; in_pc = 32'h40;
        in_rs1_data = 5; in_rs2_data = 7;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (out_alu_op !== 11'h000) begin errors++; $display("FAIL add_op: got %h want 000", out_alu_op); end
        checks++; if (out_num1 !== 32'd5) begin errors++; $display("FAIL add_num1: got %h want 5", out_num1); end
        checks++; if (out_num2 !== 32'd7) begin errors++; $display("FAIL add_num2: got %h want 7", out_num2); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL add_rd: got %0d want 1", out_rd); end
        checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL add_pc: got %h want 40", out_pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_srai();
        logic [31:0] res;
        out_ready = 1; in_valid = 1; in_instr = 32'h40415093; in_rs1_data = 32'h80000000; in_rs2_data = 0;
        step();
        in_valid = 0;
        res = 32'($signed(out_num1) >>> out_num2[4:0]);
        checks++; if (out_alu_op !== 11'h205) begin errors++; $display("FAIL srai_op: got %h want 205", out_alu_op); end
        checks++; if (out_num2 !== 32'h404) begin errors++; $display("FAIL srai_num2: got %h want 404", out_num2); end
        checks++; if (res !== 32'hF8000000) begin errors++; $display("FAIL srai_result: got %h want f8000000", res); end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        out_ready = 0; in_valid = 1; in_rs1_data = 0; in_rs2_data = 0;
        in_instr = 32'h00100293;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b want 1", in_ready); end
        step();
        in_instr = 32'h00200293;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b want 1", in_ready); end
        step();
        in_instr = 32'h00300293;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b want 0", in_ready); end
        checks++; if (out_num2 !== 32'd1) begin errors++; $display("FAIL bp_head0: got %h want 1", out_num2); end
        out_ready = 1;
        for (int k = 2; k <= 3; k++) begin
            step();
            if (k == 3) in_valid = 0;
            want = k;
            checks++; if (out_valid !== 1'b1 || out_num2 !== want)
                begin errors++; $display("FAIL bp_order%0d: got valid=%b num2=%h want num2=%h", k, out_valid, out_num2, want); end
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_forward();
        // capture-time bypass of rs2
        out_ready = 1; in_valid = 1; in_instr = 32'h003100B3; in_rs1_data = 5; in_rs2_data = 7;
        wb_en = 1; wb_rd = 3; wb_data = 32'h55;
        step();
        in_valid = 0; wb_en = 0;
        checks++; if (out_num2 !== 32'h55 || out_rs2_data !== 32'h55)
            begin errors++; $display("FAIL fwd_capture: got num2=%h rs2=%h want 55", out_num2, out_rs2_data); end
        checks++; if (out_num1 !== 32'd5) begin errors++; $display("FAIL fwd_capture_rs1: got %h want 5", out_num1); end
        step();
        // snoop into buffered entries
        out_ready = 0; in_valid = 1; in_instr = 32'h12345137; in_rs1_data = 0; in_rs2_data = 0;
        step();
        in_instr = 32'h001101B3; in_rs1_data = 32'hDEAD; in_rs2_data = 32'h10;
        step();
        in_valid = 0; wb_en = 1; wb_rd = 2; wb_data = 32'h12345000;
        step();
        wb_en = 0;
        checks++; if (out_num1 !== 32'd0 || out_num2 !== 32'h12345000 || out_rd !== 5'd2)
            begin errors++; $display("FAIL lui_head: got num1=%h num2=%h rd=%0d want 0/12345000/2", out_num1, out_num2, out_rd); end
        out_ready = 1;
        step();
        checks++; if (out_num1 !== 32'h12345000) begin errors++; $display("FAIL snoop_num1: got %h want 12345000", out_num1); end
        checks++; if (out_num2 !== 32'h10) begin errors++; $display("FAIL snoop_num2: got %h want 10", out_num2); end
        step();
        // wb_rd = 0 must never update, at capture or while buffered
        out_ready = 0; in_valid = 1; in_instr = 32'h001001B3; in_rs1_data = 0; in_rs2_data = 32'h10;
        wb_en = 1; wb_rd = 0; wb_data = 32'h12345000;
        step();
        in_valid = 0;
        step();
        wb_en = 0;
        checks++; if (out_num1 !== 32'd0) begin errors++; $display("FAIL x0_nomatch: got %h want 0", out_num1); end
        out_ready = 1;
        step();
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_instr = 32'h00100293;
        step();
        in_instr = 32'h00200293;
        step();
        flush = 1; in_instr = 32'h00300293;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", in_ready); end
        flush = 0; in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept: got %b want 0", out_valid); end
        out_ready = 1; in_valid = 1; in_instr = 32'h00400293;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_num2 !== 32'd4)
            begin errors++; $display("FAIL flush_after: got valid=%b num2=%h want 1/4", out_valid, out_num2); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 0; in_valid = 1; in_instr = 32'h00500293; in_pc = 32'h80;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %b want 1", out_valid); end
        #2 rst = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_ctrl: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        checks++; if ({out_num2, out_pc, out_rd} !== '0)
            begin errors++; $display("FAIL arst_data: got num2=%h pc=%h rd=%0d want 0", out_num2, out_pc, out_rd); end
        step();
        rst = 0;
    endtask

    task automatic test_branch_jal();
        out_ready = 1; in_valid = 1; in_instr = 32'h00208463; in_rs1_data = 3; in_rs2_data = 9;
        step();
        in_instr = 32'h0020C463;
        checks++; if (out_alu_op !== 11'h200 || out_num1 !== 32'd3 || out_num2 !== 32'd9 || out_rd !== 5'd0)
            begin errors++; $display("FAIL beq: got op=%h n1=%h n2=%h rd=%0d want 200/3/9/0", out_alu_op, out_num1, out_num2, out_rd); end
        step();
        in_instr = 32'h008000EF; in_pc = 32'h200;
        checks++; if (out_alu_op !== 11'h002) begin errors++; $display("FAIL blt: got %h want 002", out_alu_op); end
        step();
        in_valid = 0;
        checks++; if (out_num1 !== 32'h200 || out_num2 !== 32'd4 || out_rd !== 5'd1)
            begin errors++; $display("FAIL jal: got n1=%h n2=%h rd=%0d want 200/4/1", out_num1, out_num2, out_rd); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; in_instr = 32'h0000007F; in_pc = 32'hFC;
        in_rs1_data = 9; in_rs2_data = 9;
        step();
        in_instr = 32'h00001097; in_pc = 32'h100;
        checks++; if (out_illegal !== 1'b1 || out_alu_op !== 11'h000 || out_rd !== 5'd0)
            begin errors++; $display("FAIL illegal: got ill=%b op=%h rd=%0d want 1/000/0", out_illegal, out_alu_op, out_rd); end
        checks++; if (out_num1 !== 32'd0 || out_num2 !== 32'd0)
            begin errors++; $display("FAIL illegal_nums: got n1=%h n2=%h want 0/0", out_num1, out_num2); end
        step();
        in_valid = 0;
        checks++; if (out_illegal !== 1'b0 || out_num1 !== 32'h100 || out_num2 !== 32'h1000 || out_rd !== 5'd1)
            begin errors++; $display("FAIL auipc: got ill=%b n1=%h n2=%h rd=%0d want 0/100/1000/1", out_illegal, out_num1, out_num2, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_backpressure();
        test_forward();
        test_flush();
        test_async_reset();
        test_branch_jal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
